// File: rtl/pong_pixel_gen.sv
// Animated pong renderer: wall, button-driven paddle and bouncing ball, registered rgb.
// Build option: define ROUND_BALL_EN to mask the 8x8 ball with a circular ROM.
module pong_pixel_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned WALL_X_L  = 32,
    parameter int unsigned WALL_X_R  = 35,
    parameter int unsigned BAR_X_L   = 600,
    parameter int unsigned BAR_X_R   = 603,
    parameter int unsigned BAR_H     = 72,
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned BALL_V    = 2,
    parameter int unsigned BAR_V     = 4,
    parameter int unsigned COLOR_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   video_on,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    input  logic                   btn_up,
    input  logic                   btn_down,
    output logic [3*COLOR_W-1:0]   rgb,
    output logic                   hit_pulse,
    output logic                   miss_pulse
);

    localparam int unsigned PW = 10;
    localparam int unsigned SW = 11;
    localparam int unsigned RW = 3 * COLOR_W;

    localparam logic [PW-1:0] BALL_X0  = PW'(H_DISPLAY / 2);
    localparam logic [PW-1:0] BALL_Y0  = PW'(V_DISPLAY / 2);
    localparam logic [PW-1:0] BAR_TOP0 = PW'((V_DISPLAY - BAR_H) / 2);

    localparam logic [RW-1:0] RGB_RED   = RW'({{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}});
    localparam logic [RW-1:0] RGB_GREEN = RW'({{COLOR_W{1'b0}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}});
    localparam logic [RW-1:0] RGB_BLUE  = RW'({{(2*COLOR_W){1'b0}}, {COLOR_W{1'b1}}});
    localparam logic [RW-1:0] RGB_WHITE = {RW{1'b1}};

    logic [PW-1:0] ball_x_q, ball_x_d;
    logic [PW-1:0] ball_y_q, ball_y_d;
    logic [PW-1:0] bar_top_q, bar_top_d;
    logic          dx_q, dx_d;
    logic          dy_q, dy_d;
    logic          cond_q;
    logic [RW-1:0] rgb_q, rgb_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;

    logic          cond_c, tick_c;
    logic [SW-1:0] ball_r_c, ball_b_c, bar_b_c, px_c, py_c;
    logic          miss_c, pad_c, wall_c;
    logic          dx_nx, dy_nx;
    logic          wall_on_c, bar_on_c, ball_sq_c, ball_on_c;

    // Frame tick: rising edge of the first off-screen line start
    assign cond_c = (pixel_y == PW'(V_DISPLAY)) && (pixel_x == PW'(0));
    assign tick_c = cond_c & ~cond_q;

    // 11-bit extents so comparisons near the screen edge never wrap
    assign ball_r_c = SW'(ball_x_q) + SW'(BALL_SIZE - 1);
    assign ball_b_c = SW'(ball_y_q) + SW'(BALL_SIZE - 1);
    assign bar_b_c  = SW'(bar_top_q) + SW'(BAR_H - 1);
    assign px_c     = SW'(pixel_x);
    assign py_c     = SW'(pixel_y);

    assign miss_c = dx_q && (SW'(ball_x_q) >= SW'(BAR_X_R + 1));
    assign pad_c  = dx_q && (ball_r_c >= SW'(BAR_X_L)) && (ball_r_c <= SW'(BAR_X_R)) &&
                    (ball_b_c >= SW'(bar_top_q)) && (SW'(ball_y_q) <= bar_b_c);
    assign wall_c = !dx_q && (SW'(ball_x_q) <= SW'(WALL_X_R + 1));

    // Paddle motion, clamped to the visible area
    always_comb begin
        bar_top_d = bar_top_q;
        if (tick_c) begin
            if (btn_up && !btn_down) begin
                if (bar_top_q >= PW'(BAR_V)) bar_top_d = bar_top_q - PW'(BAR_V);
                else                         bar_top_d = '0;
            end else if (btn_down && !btn_up) begin
                if (SW'(bar_top_q) + SW'(BAR_H + BAR_V) <= SW'(V_DISPLAY))
                    bar_top_d = bar_top_q + PW'(BAR_V);
                else
                    bar_top_d = PW'(V_DISPLAY - BAR_H);
            end
        end
    end

    // Ball bounce and step, evaluated on the pre-update position
    always_comb begin
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        dx_nx    = dx_q;
        dy_nx    = dy_q;
        if (tick_c) begin
            if (miss_c) begin
                ball_x_d = BALL_X0;
                ball_y_d = BALL_Y0;
                dx_d     = 1'b0;
                miss_d   = 1'b1;
            end else begin
                if (pad_c) begin
                    dx_nx = 1'b0;
                    hit_d = 1'b1;
                end else if (wall_c) begin
                    dx_nx = 1'b1;
                end
                if (!dy_q && (SW'(ball_y_q) <= SW'(BALL_V)))
                    dy_nx = 1'b1;
                else if (dy_q && (SW'(ball_y_q) + SW'(BALL_SIZE) >= SW'(V_DISPLAY - BALL_V)))
                    dy_nx = 1'b0;
                dx_d     = dx_nx;
                dy_d     = dy_nx;
                ball_x_d = dx_nx ? ball_x_q + PW'(BALL_V) : ball_x_q - PW'(BALL_V);
                ball_y_d = dy_nx ? ball_y_q + PW'(BALL_V) : ball_y_q - PW'(BALL_V);
            end
        end
    end

    assign wall_on_c = (px_c >= SW'(WALL_X_L)) && (px_c <= SW'(WALL_X_R));
    assign bar_on_c  = (px_c >= SW'(BAR_X_L)) && (px_c <= SW'(BAR_X_R)) &&
                       (py_c >= SW'(bar_top_q)) && (py_c <= bar_b_c);
    assign ball_sq_c = (px_c >= SW'(ball_x_q)) && (px_c <= ball_r_c) &&
                       (py_c >= SW'(ball_y_q)) && (py_c <= ball_b_c);

`ifdef ROUND_BALL_EN
    logic [2:0] rom_row_c, rom_col_c;
    logic [7:0] rom_bits_c;

    assign rom_row_c = 3'(pixel_y - ball_y_q);
    assign rom_col_c = 3'(pixel_x - ball_x_q);

    // Circle mask, column 0 in the MSB
    always_comb begin
        rom_bits_c = 8'b0000_0000;
        case (rom_row_c)
            3'd0, 3'd7: rom_bits_c = 8'b0011_1100;
            3'd1, 3'd6: rom_bits_c = 8'b0111_1110;
            default:    rom_bits_c = 8'b1111_1111;
        endcase
    end

    assign ball_on_c = ball_sq_c && rom_bits_c[3'd7 - rom_col_c];
`else
    assign ball_on_c = ball_sq_c;
`endif

    always_comb begin
        rgb_d = RGB_WHITE;
        if (!video_on)      rgb_d = '0;
        else if (wall_on_c) rgb_d = RGB_RED;
        else if (bar_on_c)  rgb_d = RGB_BLUE;
        else if (ball_on_c) rgb_d = RGB_GREEN;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ball_x_q  <= BALL_X0;
            ball_y_q  <= BALL_Y0;
            bar_top_q <= BAR_TOP0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            cond_q    <= 1'b0;
            rgb_q     <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            bar_top_q <= bar_top_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            cond_q    <= cond_c;
            rgb_q     <= rgb_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

    assign rgb        = rgb_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Scoreboard bench for pong_pixel_gen: a frame-level game model predicts rgb and pulses per clk.
module tb_pong_pixel_gen;

    localparam int H = 640;
    localparam int V = 480;
    localparam int BAR_H = 72;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic [11:0] rgb;
    logic        hit_pulse;
    logic        miss_pulse;

    pong_pixel_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .rgb        (rgb),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       name;
        logic [11:0] rgb;
        bit          hit;
        bit          miss;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Game model state: ball corner, directions (1 = increasing), paddle top
    int bx, by, bt;
    bit mdx, mdy;
    bit prev_cond = 1'b0;
    bit up_s = 1'b0, dn_s = 1'b0, rstn_s = 1'b0;
    int n_hit = 0, n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every due scoreboard entry against the registered outputs
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (mon_e.due != cyc || rgb !== mon_e.rgb || hit_pulse !== mon_e.hit ||
                miss_pulse !== mon_e.miss) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got rgb=%h hit=%b miss=%b, want rgb=%h hit=%b miss=%b",
                         mon_e.name, cyc, rgb, hit_pulse, miss_pulse,
                         mon_e.rgb, mon_e.hit, mon_e.miss);
            end
        end
    end

    function automatic void m_reset();
        bx = H / 2; by = V / 2; bt = (V - BAR_H) / 2;
        mdx = 1'b1; mdy = 1'b1;
    endfunction

    function automatic bit in_ball(int x, int y);
        int c, r;
        c = x - bx; r = y - by;
        if (c < 0 || c > 7 || r < 0 || r > 7) return 1'b0;
`ifdef ROUND_BALL_EN
        return ((2*c - 7) * (2*c - 7) + (2*r - 7) * (2*r - 7)) <= 66;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [11:0] m_rgb(logic [9:0] x, logic [9:0] y, bit von);
        int xi, yi;
        xi = int'(x); yi = int'(y);
        if (!von) return 12'h000;
        if (xi >= 32 && xi <= 35) return 12'hF00;
        if (xi >= 600 && xi <= 603 && yi >= bt && yi < bt + BAR_H) return 12'h00F;
        if (in_ball(xi, yi)) return 12'h0F0;
        return 12'hFFF;
    endfunction

    // One frame of game rules; collision tests see the paddle before it moves
    function automatic void m_tick(bit up, bit dn, output bit h, output bit m);
        h = 1'b0; m = 1'b0;
        if (mdx && bx >= 604) begin
            m = 1'b1; bx = H / 2; by = V / 2; mdx = 1'b0;
        end else begin
            if (mdx && bx + 7 >= 600 && bx + 7 <= 603 && by + 7 >= bt && by < bt + BAR_H) begin
                mdx = 1'b0; h = 1'b1;
            end else if (!mdx && bx <= 36) begin
                mdx = 1'b1;
            end
            if (!mdy && by <= 2) mdy = 1'b1;
            else if (mdy && by + 8 >= V - 2) mdy = 1'b0;
            bx = mdx ? bx + 2 : bx - 2;
            by = mdy ? by + 2 : by - 2;
        end
        if (up && !dn) bt = (bt >= 4) ? bt - 4 : 0;
        else if (dn && !up) bt = (bt + BAR_H + 4 <= V) ? bt + 4 : V - BAR_H;
    endfunction

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input bit von, input string nm);
        bit cond, h, m;
        logic [11:0] e;
        @(posedge clk);
        #1;
        pixel_x = x; pixel_y = y; video_on = von;
        btn_up = up_s; btn_down = dn_s; reset_n = rstn_s;
        h = 1'b0; m = 1'b0;
        cond = (int'(y) == V) && (x == 10'd0);
        if (!rstn_s) begin
            e = 12'h000;
            m_reset();
            prev_cond = 1'b0;
        end else begin
            e = m_rgb(x, y, von);
            if (cond && !prev_cond) m_tick(up_s, dn_s, h, m);
            prev_cond = cond;
        end
        if (h) n_hit++;
        if (m) n_miss++;
        sb.push_back('{due: cyc + 1, name: nm, rgb: e, hit: h, miss: m});
    endtask

    // mode: 0 none, 1 up, 2 down, 3 both, 4 random per frame
    task automatic frames(input int n, input int mode, input string nm);
        for (int i = 0; i < n; i++) begin
            int b;
            b = (mode == 4) ? int'($urandom_range(0, 3)) : mode;
            up_s = b[0]; dn_s = b[1];
            drive(10'd0, 10'(V), 1'b0, nm);
            drive(10'(bx + 3), 10'(by + 3), 1'b1, "ball");
            drive(10'(bx + int'($urandom_range(0, 11)) - 2), 10'(by + int'($urandom_range(0, 11)) - 2),
                  $urandom_range(0, 9) != 0, "near");
            drive(10'($urandom_range(596, 607)), 10'(bt + int'($urandom_range(0, BAR_H + 3)) - 2),
                  1'b1, "bar");
            drive(10'($urandom_range(0, H - 1)), 10'($urandom_range(0, V - 1)),
                  $urandom_range(0, 7) != 0, "rnd");
        end
    endtask

    task automatic do_reset(input int n);
        rstn_s = 1'b0; up_s = 1'b0; dn_s = 1'b0;
        repeat (n) drive(10'd33, 10'd100, 1'b1, "rst");
        rstn_s = 1'b1;
    endtask

    initial begin
        int hit0, miss0, wait_n;
        m_reset();
        do_reset(3);

        drive(10'd33,  10'd100, 1'b1, "wall");
        drive(10'd601, 10'd210, 1'b1, "paddle");
        drive(10'd322, 10'd242, 1'b1, "ball0");
        drive(10'd100, 10'd100, 1'b1, "bg");
        drive(10'd33,  10'd100, 1'b0, "blank_w");
        drive(10'd601, 10'd210, 1'b0, "blank_p");
        drive(10'd322, 10'd242, 1'b0, "blank_b");
        drive(10'd100, 10'd100, 1'b0, "blank_bg");
        drive(10'd320, 10'd240, 1'b1, "corner0");
        drive(10'd323, 10'd240, 1'b1, "top3");

        frames(60, 1, "up");
        drive(10'd601, 10'd0, 1'b1, "bar_top0");
        drive(10'd601, 10'd72, 1'b1, "bar_end0");
        frames(5, 3, "both");

        do_reset(1);
        miss0 = n_miss;
        frames(143, 0, "idle");
        if (n_miss - miss0 != 1)
            $display("note: model miss count %0d in idle run", n_miss - miss0);
        drive(10'd322, 10'd242, 1'b1, "recentre");

        do_reset(1);
        hit0 = n_hit;
        frames(140, 2, "down");
        drive(10'd601, 10'd408, 1'b1, "bar_top408");
        drive(10'd601, 10'd407, 1'b1, "above_bar");

        up_s = 1'b0; dn_s = 1'b0;
        repeat (4) drive(10'd0, 10'(V), 1'b0, "hold");
        drive(10'(bx + 3), 10'(by + 3), 1'b1, "hold_ball");

        frames(20, 4, "pre_rst");
        rstn_s = 1'b0;
        drive(10'd322, 10'd242, 1'b1, "mid_rst");
        rstn_s = 1'b1;
        drive(10'd322, 10'd242, 1'b1, "post_rst_ball");
        drive(10'd601, 10'd210, 1'b1, "post_rst_bar");
        drive(10'd320, 10'd240, 1'b1, "post_rst_corner");

        frames(400, 4, "rand");

        wait_n = 0;
        while (sb.size() > 0 && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries pending, want 0", sb.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_pixel_gen.md
Name: pong_pixel_gen

Overview:
- Parametrised, animated successor to the fixed-object pixel generator. Renders wall, paddle and ball at run-time positions.
- Ball bounces off the wall, the top and bottom edges, and the paddle. Paddle moves under button control.
- Object state updates once per frame.
- Sits between the VGA sync generator (supplies pixel_x, pixel_y, video_on) and the DAC/output pins; rgb output is registered.

Parameters:
H_DISPLAY, 640, visible pixels per line
V_DISPLAY, 480, visible lines per frame
WALL_X_L, 32, wall left column
WALL_X_R, 35, wall right column
BAR_X_L, 600, paddle left column
BAR_X_R, 603, paddle right column
BAR_H, 72, paddle height in lines
BALL_SIZE, 8, ball side length in pixels
BALL_V, 2, ball step per frame on each axis
BAR_V, 4, paddle step per frame
COLOR_W, 4, bits per colour channel

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
video_on  in  1  visible-area flag from sync generator
pixel_x  in  10  current column
pixel_y  in  10  current line
btn_up  in  1  paddle up (debounced, level)
btn_down  in  1  paddle down (debounced, level)
rgb  out  3*COLOR_W  pixel colour {R,G,B}, registered
hit_pulse  out  1  one clk: ball struck paddle
miss_pulse  out  1  one clk: ball passed paddle

Behaviour:
- Reset (reset_n=0 at clk edge): rgb=0, hit_pulse=0, miss_pulse=0, ball_x=H_DISPLAY/2, ball_y=V_DISPLAY/2, dx=+, dy=+, bar_top=(V_DISPLAY-BAR_H)/2. Reset mid-frame restores all of these on the next edge.
- Frame tick: cond = (pixel_y==V_DISPLAY && pixel_x==0), registered. tick = cond & ~cond_q, exactly one clk per frame even if the pixel coordinates hold for several clks.
- All state updates occur only on tick. Evaluation uses the current (pre-update) position. hit_pulse and miss_pulse are registered and high for the one clk after the tick edge.
- Paddle update:
  - up only: bar_top -= BAR_V if bar_top >= BAR_V, else bar_top = 0.
  - down only: bar_top += BAR_V if bar_top+BAR_H+BAR_V <= V_DISPLAY, else bar_top = V_DISPLAY-BAR_H.
  - both or neither: hold.
- Ball direction update, in priority order:
  1. Miss: dx=+ and ball_x >= BAR_X_R+1 -> ball_x/ball_y reloaded to centre, dx=-, dy unchanged, miss_pulse. No step this tick.
  2. Paddle: dx=+ and BAR_X_L <= ball_x+BALL_SIZE-1 <= BAR_X_R and ball_y+BALL_SIZE-1 >= bar_top and ball_y <= bar_top+BAR_H-1 -> dx=-, hit_pulse.
  3. Wall: dx=- and ball_x <= WALL_X_R+1 -> dx=+.
  4. Vertical: dy=- and ball_y <= BALL_V -> dy=+; dy=+ and ball_y+BALL_SIZE >= V_DISPLAY-BALL_V -> dy=-.
  - Vertical and horizontal bounces may occur on the same tick.
- Ball step: unless a miss occurred, ball_x += or -= BALL_V and ball_y += or -= BALL_V using the new directions.
- Pixel path, computed combinationally and registered into rgb (1 clk latency from pixel_x/pixel_y/video_on), in priority order:
  - ~video_on -> 0
  - wall (WALL_X_L <= x <= WALL_X_R) -> red, all-ones R
  - paddle (BAR_X_L..BAR_X_R, bar_top..bar_top+BAR_H-1) -> blue
  - ball (ball_x..ball_x+BALL_SIZE-1, ball_y..ball_y+BALL_SIZE-1) -> green
  - otherwise white
- Arithmetic: 10-bit unsigned; sums are formed at 11 bits to avoid wrap in comparisons.

Optional Feature:
- Macro ROUND_BALL_EN.
- Defined: an 8x8 circle mask ROM, indexed by (pixel_y-ball_y, pixel_x-ball_x), gates the ball region. Requires BALL_SIZE=8. ROM row 0 = 8'b00111100 (corners clear). Masked-out pixels fall through to white.
- Undefined: square ball; no ROM is synthesised.

Test Plan:
- reset_n=0 for 3 clks, then 1 -> rgb=0, pulses 0. Sample pixels 1 clk after presentation with video_on=1: (33,100) -> F00, (601,210) -> 00F, (322,242) -> 0F0, (100,100) -> FFF. Same coordinates with video_on=0 -> 000.
- Hold btn_up for 60 ticks -> bar_top 204,200,...,0, reaching 0 at tick 51 and staying 0. btn_up and btn_down together -> no change.
- No buttons, 143 ticks -> dy flips at tick 116 (ball_y 470 -> 468). Miss at tick 143 (ball_x=604): miss_pulse one clk, ball at (320,240), dx=-.
- btn_down held from reset -> bar_top clamps at 408 by tick 51. At tick 138 (ball_x=594, ball_y=426): hit_pulse one clk, dx=- (next ball_x=592).
- Pixel coordinates held at (0,480) for 4 clks -> exactly one tick / one state update. Assert reset_n=0 mid-frame -> all state returns to reset values on the next edge.
- ROUND_BALL_EN defined -> pixel (ball_x, ball_y) is FFF and (ball_x+3, ball_y) is 0F0. Undefined -> both 0F0.
